// File: rtl/hard_sector_index_gen.sv
//-----------------------------------------------------------------------------
// hard_sector_index_gen
//
// Generates a hard-sectored disc index/sector pulse train: one pulse at the
// start of every sector slot plus an extra track-mark pulse halfway through the
// last slot of each revolution.  All timing advances on cke ticks so gap
// lengths match the time base of the track-mark detection path.
//
// Ports:
//   clock_i        system clock, positive edge
//   reset_i        asynchronous active-high reset
//   cke_i          tick enable; timing advances only on clocks with cke_i=1
//   enable_i       run request
//   sectors_i      sector holes per revolution (N)
//   period_i       ticks between sector pulses (P)
//   pulse_width_i  requested pulse high time in ticks (W)
//   index_o        registered pulse train, active high
//   sector_o       current slot number 0..N-1
//   track_mark_o   high while the half-slot track-mark pulse is driven
//   rev_strobe_o   one-clock strobe on each wrap to slot 0
//   running_o      generator in RUN state
//-----------------------------------------------------------------------------
`timescale 1ns/1ps
module hard_sector_index_gen #(
  parameter int SECTOR_W = 6,
  parameter int PERIOD_W = 16
) (
  input  logic                clock_i,
  input  logic                reset_i,
  input  logic                cke_i,
  input  logic                enable_i,
  input  logic [SECTOR_W-1:0] sectors_i,
  input  logic [PERIOD_W-1:0] period_i,
  input  logic [7:0]          pulse_width_i,
  output logic                index_o,
  output logic [SECTOR_W-1:0] sector_o,
  output logic                track_mark_o,
  output logic                rev_strobe_o,
  output logic                running_o
);

  // Comparison width wide enough for both the tick counter and the 8-bit
  // pulse width, plus one bit of headroom for H + Weff.
  localparam int CW = ((PERIOD_W > 8) ? PERIOD_W : 8) + 1;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [PERIOD_W-1:0] t_q, t_d;
  logic [SECTOR_W-1:0] s_q, s_d;
  logic [SECTOR_W-1:0] nl_q, nl_d;
  logic [PERIOD_W-1:0] pl_q, pl_d;
  logic [7:0]          wl_q, wl_d;
  logic                index_q, index_d;
  logic                tm_q, tm_d;
  logic                rev_q, rev_d;

  logic [CW-1:0]       h_c, w_c, tx_c;

  function automatic logic cfg_valid(input logic [SECTOR_W-1:0] n,
                                     input logic [PERIOD_W-1:0] p);
    return (n != '0) && (p >= PERIOD_W'(4));
  endfunction

  function automatic logic [CW-1:0] half_of(input logic [PERIOD_W-1:0] p);
    return CW'(p >> 1);
  endfunction

  // Effective pulse width: clamped to H-1 so the track-mark pulse never
  // touches the neighbouring sector pulse, and never shorter than one tick.
  function automatic logic [CW-1:0] weff_of(input logic [PERIOD_W-1:0] p,
                                            input logic [7:0]          w);
    logic [CW-1:0] hm1;
    logic [CW-1:0] wx;
    logic [CW-1:0] m;
    hm1 = CW'(p >> 1) - CW'(1);
    wx  = CW'(w);
    m   = (wx < hm1) ? wx : hm1;
    return (m == '0) ? CW'(1) : m;
  endfunction

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    s_d     = s_q;
    nl_d    = nl_q;
    pl_d    = pl_q;
    wl_d    = wl_q;
    index_d = index_q;
    tm_d    = tm_q;
    rev_d   = 1'b0;

    if (cke_i) begin
      if (state_q == IDLE) begin
        if (enable_i && cfg_valid(sectors_i, period_i)) begin
          state_d = RUN;
          t_d     = '0;
          s_d     = '0;
          nl_d    = sectors_i;
          pl_d    = period_i;
          wl_d    = pulse_width_i;
          rev_d   = 1'b1;
        end
      end else begin
        if (t_q == pl_q - PERIOD_W'(1)) begin
          t_d = '0;
          if (!enable_i) begin
            // Stop only at a slot boundary, so any started pulse has finished.
            state_d = IDLE;
            s_d     = '0;
          end else if (s_q == nl_q - SECTOR_W'(1)) begin
            s_d = '0;
            if (cfg_valid(sectors_i, period_i)) begin
              nl_d  = sectors_i;
              pl_d  = period_i;
              wl_d  = pulse_width_i;
              rev_d = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_d = s_q + SECTOR_W'(1);
          end
        end else begin
          t_d = t_q + PERIOD_W'(1);
        end
      end
    end

    // Outputs are decoded from the next-state values so they are registered
    // alongside the state they describe.
    h_c  = half_of(pl_d);
    w_c  = weff_of(pl_d, wl_d);
    tx_c = CW'(t_d);
    if (cke_i) begin
      tm_d    = (state_d == RUN) && (s_d == nl_d - SECTOR_W'(1)) &&
                (tx_c >= h_c) && (tx_c < h_c + w_c);
      index_d = (state_d == RUN) && ((tx_c < w_c) || tm_d);
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      t_q     <= '0;
      s_q     <= '0;
      nl_q    <= '0;
      pl_q    <= '0;
      wl_q    <= '0;
      index_q <= 1'b0;
      tm_q    <= 1'b0;
      rev_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      s_q     <= s_d;
      nl_q    <= nl_d;
      pl_q    <= pl_d;
      wl_q    <= wl_d;
      index_q <= index_d;
      tm_q    <= tm_d;
      rev_q   <= rev_d;
    end
  end

  assign index_o      = index_q;
  assign sector_o     = s_q;
  assign track_mark_o = tm_q;
  assign rev_strobe_o = rev_q;
  assign running_o    = (state_q == RUN);

endmodule

// File: tb/tb_hard_sector_index_gen.sv
`timescale 1ns/1ps
module tb_hard_sector_index_gen;

  logic        clock_i, reset_i, cke_i, enable_i;
  logic [5:0]  sectors_i;
  logic [15:0] period_i;
  logic [7:0]  pulse_width_i;
  logic        index_o, track_mark_o, rev_strobe_o, running_o;
  logic [5:0]  sector_o;

  hard_sector_index_gen #(.SECTOR_W(6), .PERIOD_W(16)) dut (
    .clock_i       (clock_i),
    .reset_i       (reset_i),
    .cke_i         (cke_i),
    .enable_i      (enable_i),
    .sectors_i     (sectors_i),
    .period_i      (period_i),
    .pulse_width_i (pulse_width_i),
    .index_o       (index_o),
    .sector_o      (sector_o),
    .track_mark_o  (track_mark_o),
    .rev_strobe_o  (rev_strobe_o),
    .running_o     (running_o)
  );

  initial begin
    clock_i = 1'b0;
    forever #5 clock_i = ~clock_i;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  int n_checks = 0;
  int n_fail   = 0;

  int cur_cke, cur_en, cur_n, cur_p, cur_w;

  // Reference model: position within the revolution as a single tick count.
  bit m_run;
  int m_k, m_N, m_P, m_W;
  int e_idx, e_tm, e_rev, e_sec, e_run;

  int cyc;
  int rises[$];
  bit prev_idx;
  int tm_cnt, tm_first, idx0_cnt;
  int exp_r[16];

  typedef struct {
    int cke, en, n, p, w;
    int idx, tm, rev, sec, run;
  } vec_t;
  vec_t vt[18];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 1'b0; m_k = 0; m_N = 0; m_P = 0; m_W = 0;
    e_idx = 0; e_tm = 0; e_rev = 0; e_sec = 0; e_run = 0;
  endtask

  task automatic model_step();
    int slot, off, h, we;
    e_rev = 0;
    if (cur_cke != 0) begin
      if (!m_run) begin
        if (cur_en != 0 && cur_n >= 1 && cur_p >= 4) begin
          m_run = 1'b1; m_k = 0; m_N = cur_n; m_P = cur_p; m_W = cur_w; e_rev = 1;
        end
      end else if (m_k % m_P == m_P - 1) begin
        if (cur_en == 0) m_run = 1'b0;
        else if (m_k == m_N * m_P - 1) begin
          if (cur_n >= 1 && cur_p >= 4) begin
            m_N = cur_n; m_P = cur_p; m_W = cur_w; m_k = 0; e_rev = 1;
          end else m_run = 1'b0;
        end else m_k++;
      end else m_k++;

      if (m_run) begin
        slot = m_k / m_P;
        off  = m_k % m_P;
        h    = m_P / 2;
        we   = (m_W < h - 1) ? m_W : h - 1;
        if (we < 1) we = 1;
        e_tm  = (slot == m_N - 1 && off >= h && off < h + we) ? 1 : 0;
        e_idx = (off < we || e_tm == 1) ? 1 : 0;
        e_sec = slot;
        e_run = 1;
      end else begin
        e_idx = 0; e_tm = 0; e_sec = 0; e_run = 0;
      end
    end
  endtask

  task automatic check_model();
    chk("index",      32'(index_o),      e_idx);
    chk("track_mark", 32'(track_mark_o), e_tm);
    chk("rev_strobe", 32'(rev_strobe_o), e_rev);
    chk("sector",     32'(sector_o),     e_sec);
    chk("running",    32'(running_o),    e_run);
  endtask

  task automatic step(input bit mchk);
    cke_i         = cur_cke[0];
    enable_i      = cur_en[0];
    sectors_i     = cur_n[5:0];
    period_i      = cur_p[15:0];
    pulse_width_i = cur_w[7:0];
    @(posedge clock_i);
    model_step();
    #1;
    if (mchk) check_model();
    if (index_o && !prev_idx) rises.push_back(cyc);
    if (track_mark_o) begin
      tm_cnt++;
      if (tm_first < 0) tm_first = cyc;
    end
    if (index_o && cyc < 8) idx0_cnt++;
    prev_idx = index_o;
    cyc++;
  endtask

  task automatic begin_seq(input int n, input int p, input int w);
    rises.delete();
    cyc = 0; prev_idx = 1'b0; tm_cnt = 0; tm_first = -1; idx0_cnt = 0;
    cur_cke = 1; cur_en = 1; cur_n = n; cur_p = p; cur_w = w;
  endtask

  task automatic check_reset_vals(input string nm);
    chk({nm, "_index"},      32'(index_o),      0);
    chk({nm, "_track_mark"}, 32'(track_mark_o), 0);
    chk({nm, "_rev_strobe"}, 32'(rev_strobe_o), 0);
    chk({nm, "_sector"},     32'(sector_o),     0);
    chk({nm, "_running"},    32'(running_o),    0);
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    #2;
    model_reset();
    check_reset_vals("rst");
    @(posedge clock_i);
    #1;
    reset_i = 1'b0;
    prev_idx = 1'b0;
  endtask

  task automatic check_rises(input string nm, input int cnt);
    chk({nm, "_count"}, rises.size(), cnt);
    for (int i = 0; i < cnt; i++)
      chk(nm, (i < rises.size()) ? rises[i] : -1, exp_r[i]);
  endtask

  initial begin
    // {cke, en, N, P, W, index, track_mark, rev_strobe, sector, running}
    vt[0]  = '{1, 1, 0, 8, 3, 0, 0, 0, 0, 0};  // sectors=0: stay idle
    vt[1]  = '{1, 1, 4, 3, 3, 0, 0, 0, 0, 0};  // period=3: stay idle
    vt[2]  = '{0, 1, 2, 4, 3, 0, 0, 0, 0, 0};  // valid but no tick
    vt[3]  = '{1, 1, 2, 4, 3, 1, 0, 1, 0, 1};  // start, tick 0
    vt[4]  = '{0, 1, 2, 4, 3, 1, 0, 0, 0, 1};  // hold, strobe clears
    vt[5]  = '{1, 1, 2, 4, 3, 0, 0, 0, 0, 1};  // tick 1 (Weff=1)
    vt[6]  = '{1, 1, 2, 4, 3, 0, 0, 0, 0, 1};
    vt[7]  = '{1, 1, 2, 4, 3, 0, 0, 0, 0, 1};
    vt[8]  = '{1, 1, 2, 4, 3, 1, 0, 0, 1, 1};  // tick 4, slot 1
    vt[9]  = '{1, 1, 2, 4, 3, 0, 0, 0, 1, 1};
    vt[10] = '{1, 1, 2, 4, 3, 1, 1, 0, 1, 1};  // tick 6, track mark
    vt[11] = '{0, 1, 2, 4, 3, 1, 1, 0, 1, 1};  // hold
    vt[12] = '{1, 1, 2, 4, 3, 0, 0, 0, 1, 1};
    vt[13] = '{1, 1, 2, 4, 3, 1, 0, 1, 0, 1};  // wrap
    vt[14] = '{1, 0, 2, 4, 3, 0, 0, 0, 0, 1};  // enable low mid-slot
    vt[15] = '{1, 0, 2, 4, 3, 0, 0, 0, 0, 1};
    vt[16] = '{1, 0, 2, 4, 3, 0, 0, 0, 0, 1};
    vt[17] = '{1, 0, 2, 4, 3, 0, 0, 0, 0, 0};  // boundary: stop

    reset_i = 1'b1; cke_i = 1'b0; enable_i = 1'b0;
    sectors_i = '0; period_i = '0; pulse_width_i = '0;
    cur_cke = 0; cur_en = 0; cur_n = 0; cur_p = 0; cur_w = 0;
    model_reset();
    repeat (2) @(posedge clock_i);
    #1;
    check_reset_vals("init");
    reset_i = 1'b0;

    // Table-driven vectors
    begin_seq(0, 0, 0);
    for (int i = 0; i < 18; i++) begin
      cur_cke = vt[i].cke; cur_en = vt[i].en; cur_n = vt[i].n;
      cur_p = vt[i].p; cur_w = vt[i].w;
      step(1'b1);
      chk($sformatf("tbl%0d_index", i),      32'(index_o),      vt[i].idx);
      chk($sformatf("tbl%0d_track_mark", i), 32'(track_mark_o), vt[i].tm);
      chk($sformatf("tbl%0d_rev_strobe", i), 32'(rev_strobe_o), vt[i].rev);
      chk($sformatf("tbl%0d_sector", i),     32'(sector_o),     vt[i].sec);
      chk($sformatf("tbl%0d_running", i),    32'(running_o),    vt[i].run);
    end

    // Basic N=4 P=8 W=2: gaps 8,8,8,4,4
    do_reset();
    begin_seq(4, 8, 2);
    for (int i = 0; i < 40; i++) step(1'b1);
    exp_r[0] = 0; exp_r[1] = 8; exp_r[2] = 16; exp_r[3] = 24; exp_r[4] = 28; exp_r[5] = 32;
    check_rises("basic_rise", 6);
    chk("basic_tm_first", tm_first, 28);
    chk("basic_tm_cnt", tm_cnt, 2);

    // cke every third clock: everything stretches by 3x
    do_reset();
    begin_seq(4, 8, 2);
    for (int i = 0; i < 100; i++) begin
      cur_cke = (i % 3 == 0) ? 1 : 0;
      step(1'b1);
    end
    exp_r[0] = 0; exp_r[1] = 24; exp_r[2] = 48; exp_r[3] = 72; exp_r[4] = 84; exp_r[5] = 96;
    check_rises("cke3_rise", 6);

    // W=10 with P=8 clamps to Weff=3
    do_reset();
    begin_seq(4, 8, 10);
    for (int i = 0; i < 40; i++) step(1'b1);
    exp_r[0] = 0; exp_r[1] = 8; exp_r[2] = 16; exp_r[3] = 24; exp_r[4] = 28; exp_r[5] = 32;
    check_rises("wclamp_rise", 6);
    chk("wclamp_width", idx0_cnt, 3);
    chk("wclamp_tm_first", tm_first, 28);
    chk("wclamp_tm_cnt", tm_cnt, 3);

    // Sector count change mid-revolution takes effect at the wrap
    do_reset();
    begin_seq(4, 8, 2);
    for (int i = 0; i < 82; i++) begin
      if (i == 10) cur_n = 6;
      step(1'b1);
    end
    exp_r[0] = 0;  exp_r[1] = 8;  exp_r[2] = 16; exp_r[3] = 24; exp_r[4] = 28;
    exp_r[5] = 32; exp_r[6] = 40; exp_r[7] = 48; exp_r[8] = 56; exp_r[9] = 64;
    exp_r[10] = 72; exp_r[11] = 76; exp_r[12] = 80;
    check_rises("ncfg_rise", 13);

    // Enable dropped in slot 3: track mark still emitted, then stop
    do_reset();
    begin_seq(4, 8, 2);
    for (int i = 0; i < 40; i++) begin
      if (i == 26) cur_en = 0;
      step(1'b1);
      if (i == 32) begin
        chk("stop_running", 32'(running_o), 0);
        chk("stop_index",   32'(index_o),   0);
        chk("stop_sector",  32'(sector_o),  0);
      end
    end
    exp_r[0] = 0; exp_r[1] = 8; exp_r[2] = 16; exp_r[3] = 24; exp_r[4] = 28;
    check_rises("stop_rise", 5);
    chk("stop_tm_cnt", tm_cnt, 2);

    // Reset asserted in the middle of a pulse drops outputs without a clock
    do_reset();
    begin_seq(4, 8, 2);
    step(1'b1);
    chk("prerst_index", 32'(index_o), 1);
    #3;
    reset_i = 1'b1;
    #1;
    check_reset_vals("midrst");
    model_reset();
    @(posedge clock_i);
    #1;
    reset_i = 1'b0;
    cur_en = 0;
    step(1'b1);
    cur_en = 1;
    step(1'b1);
    chk("restart_rev", 32'(rev_strobe_o), 1);

    // Randomized run against the model
    do_reset();
    begin_seq(3, 8, 2);
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        cur_n = $urandom_range(0, 5);
        cur_p = $urandom_range(3, 12);
        cur_w = $urandom_range(0, 8);
      end
      cur_cke = ($urandom_range(0, 3) != 0) ? 1 : 0;
      if ($urandom_range(0, 49) == 0) cur_en = 1 - cur_en;
      step(1'b1);
    end

    // N=1 with the maximum period
    do_reset();
    begin_seq(1, 65535, 200);
    for (int i = 0; i < 65537; i++) step(1'b1);
    exp_r[0] = 0; exp_r[1] = 32767; exp_r[2] = 65535;
    check_rises("pmax_rise", 3);
    chk("pmax_tm_cnt", tm_cnt, 200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hard_sector_index_gen.md
Name: hard_sector_index_gen

Overview:
- Generates a hard-sectored disc index/sector pulse train: one pulse per sector hole, plus the extra track-mark hole halfway between the last sector and sector 0.
- Used for drive emulation and for loopback self-test of the track-mark detection path.
- Timing is counted in cke ticks, the same time base the detection path uses, so gap lengths are directly comparable to its threshold.

Parameters:
- SECTOR_W, 6, width of sectors input and sector output (max 63 sectors).
- PERIOD_W, 16, width of period input and internal tick counter.

Ports:
- clock  in  1  system clock, positive-edge
- reset  in  1  asynchronous, active-high reset
- cke  in  1  tick enable; all timing advances only on clock edges with cke=1
- enable  in  1  run request
- sectors  in  SECTOR_W  sector holes per revolution (N)
- period  in  PERIOD_W  ticks between successive sector pulses (P)
- pulse_width  in  8  pulse high time in ticks (W)
- index  out  1  generated pulse train, active high, registered
- sector  out  SECTOR_W  current slot number, 0..N-1
- track_mark  out  1  high while the half-slot track-mark pulse is driven
- rev_strobe  out  1  one-clock strobe on each wrap to slot 0
- running  out  1  generator in RUN state

Behaviour:
- Reset (async, active-high): state IDLE; index, track_mark, rev_strobe, running = 0; sector = 0; tick counter = 0; latched config = 0.
- Config latch (Nl, Pl, Wl) is loaded on entering RUN and on every wrap to slot 0. Mid-revolution input changes are ignored.
- Config validity: N>=1 and P>=4. Invalid config in IDLE: stay IDLE. Invalid config at a wrap: go IDLE.
- Derived values:
  - H = floor(Pl/2).
  - Weff = max(1, min(Wl, H-1)). Pulses never merge.
- States:
  - IDLE: on a cke edge with enable=1 and valid config, go to RUN with t=0, s=0. On that same edge, index=1, running=1, rev_strobe=1. Latency is one clock from the sampled cke edge.
  - RUN, on each cke edge:
    - If t==Pl-1: t<=0 and s advances (s==Nl-1 wraps to 0 and pulses rev_strobe).
    - Otherwise t<=t+1.
  - Stop: if enable=0 when a slot boundary is reached (t==Pl-1), go to IDLE. index=0, running=0, sector=0. A pulse already started, including the track-mark pulse, always completes.
- Output function, registered from the next-state values:
  - index = RUN && (t<Weff || (s==Nl-1 && t>=H && t<H+Weff)).
  - track_mark = RUN && s==Nl-1 && H<=t<H+Weff.
- cke=0 edges: all state and outputs hold, except rev_strobe, which clears after one clock.
- N=1: every slot is the last slot. Each revolution is a sector pulse at 0 and a track-mark pulse at H.
- Tick counter width PERIOD_W. P=2^PERIOD_W-1 is the maximum; no overflow.
- Reset mid-pulse: index drops asynchronously; the generator restarts only from IDLE.

Test Plan:
- N=4, P=8, W=2, cke=1, enable pulsed high then held:
  - index high during ticks 0-1, 8-9, 16-17, 24-25, 28-29 (track_mark=1), then 32-33 with rev_strobe, sector=0.
  - Gap sequence is 8,8,8,4,4 and repeats.
- Same config with cke=1 only every 3rd clock -> all edges stretch by exactly 3x in clocks; outputs hold on non-cke clocks.
- W=10, P=8 -> Weff=3 (H=4):
  - Sector pulses are 3 ticks.
  - Track mark spans ticks 4-6 of the last slot; index returns low for at least 1 tick before the next pulse.
- Change sectors 4->6 at tick 10 -> the current revolution completes with 4 slots; the 6-slot pattern starts at the wrap (tick 32).
- Deassert enable at tick 26 (slot 3) -> track-mark pulse at 28-29 is still emitted; at tick 32 index stays 0, running=0, sector=0.
- period=3 or sectors=0 with enable=1 -> remains IDLE, index=0. Assert reset during a pulse -> index=0 immediately, all outputs at reset values.
- Loopback: generator output into the track-mark detector with threshold=5 -> detect asserts following each sector-0 pulse, once per revolution.
